// File: rtl/clk_lock_sequencer.sv
`default_nettype none
// =============================================================================
// clk_lock_sequencer : drives MMCM reset, qualifies locked, releases sys_rst_n
// Revision           : 1.0
// =============================================================================
module clk_lock_sequencer #(
   parameter int RST_CYCLES    = 8,
   parameter int STABLE_CYCLES = 64,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int HOLD_CYCLES   = 16,
   parameter int MAX_RETRY     = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk_in1,
   input  logic             reset_n,
   input  logic             locked,
   output logic             mmcm_reset,
   output logic             sys_rst_n,
   output logic             ready,
   output logic             fail,
   output logic [7:0]       retry_cnt,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   localparam int CYC_MAX_A = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
   localparam int CYC_MAX   = (LOCK_TIMEOUT > CYC_MAX_A) ? LOCK_TIMEOUT : CYC_MAX_A;
   localparam int CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int STAB_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   localparam logic [CYC_W-1:0]  C_RST_LAST  = CYC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0]  C_TO_LAST   = CYC_W'(LOCK_TIMEOUT - 1);
   localparam logic [CYC_W-1:0]  C_HOLD_LAST = CYC_W'(HOLD_CYCLES - 1);
   localparam logic [STAB_W-1:0] C_STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [7:0]        C_MAX_RETRY = 8'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_MRST = 3'd0,
      S_WAIT = 3'd1,
      S_HOLD = 3'd2,
      S_RUN  = 3'd3,
      S_FAIL = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_lk_meta;
   logic                r_lk_s;
   logic [CYC_W-1:0]    r_cyc;
   logic [STAB_W-1:0]   r_stab;

   always_ff @(posedge clk_in1 or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_MRST;
         r_lk_meta     <= 1'b0;
         r_lk_s        <= 1'b0;
         r_cyc         <= '0;
         r_stab        <= '0;
         mmcm_reset    <= 1'b1;
         sys_rst_n     <= 1'b0;
         ready         <= 1'b0;
         fail          <= 1'b0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
      end else begin
         r_lk_meta <= locked;
         r_lk_s    <= r_lk_meta;
         case (r_state)
            S_MRST: begin
               if (r_cyc == C_RST_LAST) begin
                  r_state    <= S_WAIT;
                  r_cyc      <= '0;
                  r_stab     <= '0;
                  mmcm_reset <= 1'b0;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            S_WAIT: begin
               // Stable completion wins over a timeout landing on the same cycle.
               if (r_lk_s && (r_stab == C_STAB_LAST)) begin
                  r_state <= S_HOLD;
                  r_cyc   <= '0;
               end else if (r_cyc == C_TO_LAST) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  r_cyc     <= '0;
                  if ((retry_cnt + 8'd1) == C_MAX_RETRY) begin
                     r_state <= S_FAIL;
                     fail    <= 1'b1;
                  end else begin
                     r_state    <= S_MRST;
                     mmcm_reset <= 1'b1;
                  end
               end else begin
                  r_cyc  <= r_cyc + CYC_W'(1);
                  r_stab <= r_lk_s ? (r_stab + STAB_W'(1)) : '0;
               end
            end
            S_HOLD: begin
               if (!r_lk_s) begin
                  r_state    <= S_MRST;
                  r_cyc      <= '0;
                  mmcm_reset <= 1'b1;
               end else if (r_cyc == C_HOLD_LAST) begin
                  r_state   <= S_RUN;
                  r_cyc     <= '0;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            S_RUN: begin
               if (!r_lk_s) begin
                  r_state    <= S_MRST;
                  r_cyc      <= '0;
                  mmcm_reset <= 1'b1;
                  sys_rst_n  <= 1'b0;
                  ready      <= 1'b0;
                  if (lock_loss_cnt != '1)
                     lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
               end
            end
            S_FAIL: begin
               r_state <= S_FAIL;
            end
            default: begin
               r_state    <= S_MRST;
               r_cyc      <= '0;
               mmcm_reset <= 1'b1;
               sys_rst_n  <= 1'b0;
               ready      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
